// File: rtl/minv_io_ctrl_if.sv
// Host word bus plus inversion-engine handshake for minv_io_ctrl.
// The slave modport is the controller's view; master is the host/engine side.
interface minv_io_ctrl_if #(
    parameter int DW = 32
);
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          minv_en;
    logic [255:0]  opa;
    logic [255:0]  modp;
    logic          set_minv_rdy;
    logic [255:0]  minv_res;
    logic          busy;
    logic          err;

    modport slave (
        input  din, din_valid, dout_ready, set_minv_rdy, minv_res,
        output din_ready, dout, dout_valid, minv_en, opa, modp, busy, err
    );

    modport master (
        output din, din_valid, dout_ready, set_minv_rdy, minv_res,
        input  din_ready, dout, dout_valid, minv_en, opa, modp, busy, err
    );
endinterface

// File: rtl/minv_io_ctrl.sv
// Word-serial loader/unloader around a 256-bit modular-inversion engine.
// Rejects operands the engine cannot invert (a==0, p even, p<=1) with err and a zero result.
//
// state    | meaning
// S_IDLE   | waiting for the first operand word (a word 0)
// S_LOAD_A | collecting a words 1..NW-1
// S_LOAD_P | collecting p words 0..NW-1
// S_CHECK  | operand sanity check
// S_START  | one-cycle minv_en pulse
// S_WAIT   | engine running, waiting for set_minv_rdy
// S_UNLOAD | streaming the result buffer out, LS word first
module minv_io_ctrl #(
    parameter int DW = 32,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    minv_io_ctrl_if.slave bus
);
    localparam int OW = DW * NW;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_P, S_CHECK, S_START, S_WAIT, S_UNLOAD
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [OW-1:0] r_opa;
    logic [OW-1:0] r_modp;
    logic [OW-1:0] r_buf;
    logic          r_err;

    logic w_din_xfer;
    logic w_dout_xfer;
    logic w_last;
    logic w_bad;
    logic w_capture;

    assign w_din_xfer  = bus.din_valid & bus.din_ready;
    assign w_dout_xfer = bus.dout_valid & bus.dout_ready;
    assign w_last      = (r_cnt == CW'(NW - 1));
    assign w_bad       = (r_opa == '0) || !r_modp[0] || (r_modp <= OW'(1));
    assign w_capture   = bus.set_minv_rdy && ((r_state == S_START) || (r_state == S_WAIT));

    always_comb begin
        w_next         = r_state;
        bus.din_ready  = 1'b0;
        bus.dout_valid = 1'b0;
        bus.minv_en    = 1'b0;
        bus.busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.din_ready = 1'b1;
                if (w_din_xfer) w_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                bus.din_ready = 1'b1;
                if (w_din_xfer && w_last) w_next = S_LOAD_P;
            end
            S_LOAD_P: begin
                bus.din_ready = 1'b1;
                if (w_din_xfer && w_last) w_next = S_CHECK;
            end
            S_CHECK:  w_next = w_bad ? S_UNLOAD : S_START;
            S_START: begin
                bus.minv_en = 1'b1;
                w_next      = w_capture ? S_UNLOAD : S_WAIT;
            end
            S_WAIT:   if (w_capture) w_next = S_UNLOAD;
            S_UNLOAD: begin
                bus.dout_valid = 1'b1;
                if (w_dout_xfer && w_last) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
        if (r_state != S_IDLE) bus.busy = 1'b1;
        // Handshake outputs are forced quiet combinationally while reset is held,
        // since the synchronous reset has not yet reached the state register.
        if (rst) begin
            bus.din_ready  = 1'b0;
            bus.dout_valid = 1'b0;
            bus.minv_en    = 1'b0;
            bus.busy       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_opa   <= '0;
            r_modp  <= '0;
            r_buf   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_din_xfer || w_dout_xfer)
                r_cnt <= r_cnt + CW'(1);

            case (r_state)
                S_IDLE: begin
                    if (w_din_xfer) begin
                        r_opa[DW-1:0] <= bus.din;
                        r_err         <= 1'b0;
                        r_cnt         <= CW'(1);
                    end
                end
                S_LOAD_A: if (w_din_xfer) r_opa[int'(r_cnt)*DW +: DW]  <= bus.din;
                S_LOAD_P: if (w_din_xfer) r_modp[int'(r_cnt)*DW +: DW] <= bus.din;
                S_CHECK: begin
                    if (w_bad) begin
                        r_err <= 1'b1;
                        r_buf <= '0;
                    end
                end
                S_START, S_WAIT: if (w_capture) r_buf <= bus.minv_res;
                default: ;
            endcase
        end
    end

    assign bus.dout = r_buf[int'(r_cnt)*DW +: DW];
    assign bus.opa  = r_opa;
    assign bus.modp = r_modp;
    assign bus.err  = r_err;
endmodule

// File: tb/tb_minv_io_ctrl.sv
// Self-checking bench for minv_io_ctrl: directed and random jobs against an
// operand-level model of load / check / engine handshake / unload.
module tb_minv_io_ctrl;
    localparam int DW = 32;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    minv_io_ctrl_if #(.DW(DW)) bus ();

    minv_io_ctrl #(.DW(DW), .NW(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Streams a then p, LS word first; optional idle cycle between words with junk on din.
    task automatic load(input logic [255:0] a, input logic [255:0] p, input bit toggle);
        for (int w = 0; w < 2*NW; w++) begin
            if (toggle && w > 0) begin
                bus.din_valid = 1'b0;
                bus.din       = $urandom;
                @(negedge clk);
            end
            bus.din       = (w < NW) ? a[w*DW +: DW] : p[(w-NW)*DW +: DW];
            bus.din_valid = 1'b1;
            chk("din_ready_load", bus.din_ready, 1);
            @(negedge clk);
            if (w == 0) begin
                chk("busy_after_w0", bus.busy, 1);
                chk("err_cleared_w0", bus.err, 0);
            end
        end
        bus.din_valid = 1'b0;
        bus.din       = $urandom;
    endtask

    task automatic run_job(input logic [255:0] a, input logic [255:0] p, input int d,
                           input bit toggle, input int sw, input int sl,
                           input logic [255:0] res);
        logic         exp_err;
        logic [255:0] exp_buf;
        int           pulses;
        int           t;
        int           t_en;
        bit           rdy_done;
        exp_err  = (a == 0) || (p[0] == 1'b0) || (p <= 1);
        exp_buf  = exp_err ? '0 : res;
        pulses   = 0;
        t        = 0;
        t_en     = -1;
        rdy_done = 0;
        bus.minv_res = res;
        load(a, p, toggle);
        chk("busy_check_state", bus.busy, 1);
        chk("din_ready_check_state", bus.din_ready, 0);
        while (!bus.dout_valid && t < 200) begin
            if (bus.minv_en) begin
                pulses++;
                t_en = t;
                chk("opa_at_en", bus.opa, a);
                chk("modp_at_en", bus.modp, p);
            end
            if (t_en >= 0 && t == t_en + d && !rdy_done) begin
                bus.set_minv_rdy = 1'b1;
                rdy_done = 1;
            end else begin
                bus.set_minv_rdy = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        bus.set_minv_rdy = 1'b0;
        chk("dout_valid_reached", bus.dout_valid, 1);
        chk("minv_en_pulses", pulses, exp_err ? 0 : 1);
        if (exp_err) chk("err_path_latency", t, 1);
        else         chk("unload_latency", t - t_en, d + 1);
        chk("err_at_unload", bus.err, exp_err);
        for (int w = 0; w < NW; w++) begin
            if (w == sw) begin
                for (int s = 0; s < sl; s++) begin
                    bus.dout_ready = 1'b0;
                    chk("dout_hold", bus.dout, exp_buf[w*DW +: DW]);
                    @(negedge clk);
                end
            end
            chk("dout_valid_w", bus.dout_valid, 1);
            chk("dout_word", bus.dout, exp_buf[w*DW +: DW]);
            chk("minv_en_unload", bus.minv_en, 0);
            bus.dout_ready = 1'b1;
            @(negedge clk);
        end
        bus.dout_ready = 1'b0;
        chk("busy_end", bus.busy, 0);
        chk("dout_valid_end", bus.dout_valid, 0);
        chk("err_end", bus.err, exp_err);
        chk("din_ready_end", bus.din_ready, 1);
    endtask

    initial begin
        logic [255:0] a;
        logic [255:0] p;
        int           n;
        rst              = 1'b1;
        bus.din          = '0;
        bus.din_valid    = 1'b0;
        bus.dout_ready   = 1'b0;
        bus.set_minv_rdy = 1'b0;
        bus.minv_res     = '0;
        #1;
        chk("rst_busy_t0", bus.busy, 0);
        chk("rst_din_ready_t0", bus.din_ready, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_din_ready", bus.din_ready, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_minv_en", bus.minv_en, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_din_ready", bus.din_ready, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_err", bus.err, 0);
        chk("idle_opa", bus.opa, 0);
        chk("idle_modp", bus.modp, 0);

        run_job(256'd3, 256'd7, 20, 0, -1, 0, 256'd5);
        run_job(256'd0, 256'd7, 5, 0, -1, 0, rnd256());
        run_job(256'd3, 256'd8, 5, 0, -1, 0, rnd256());
        run_job(256'd3, 256'd7, 20, 1, 4, 3, 256'd5);
        run_job(256'd3, 256'd1, 5, 0, -1, 0, rnd256());
        run_job(rnd256(), rnd256() | 256'd1, 0, 0, 2, 2, rnd256());

        for (int j = 0; j < 6; j++) begin
            a = rnd256();
            if ($urandom_range(0, 3) == 0) a = '0;
            p = rnd256();
            if ($urandom_range(0, 1) == 1) p[0] = 1'b1;
            run_job(a, p, $urandom_range(0, 30), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7), $urandom_range(0, 4), rnd256());
        end

        // Abort in WAIT: a late engine done must not produce output.
        bus.minv_res = rnd256();
        load(256'd3, 256'd7, 0);
        n = 0;
        while (!bus.minv_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_minv_en_seen", bus.minv_en, 1);
        repeat (3) @(negedge clk);
        chk("abort_busy_wait", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_rst_busy", bus.busy, 0);
        chk("abort_rst_din_ready", bus.din_ready, 0);
        @(negedge clk);
        chk("abort_opa_clr", bus.opa, 0);
        chk("abort_modp_clr", bus.modp, 0);
        chk("abort_err_clr", bus.err, 0);
        rst = 1'b0;
        bus.set_minv_rdy = 1'b1;
        @(negedge clk);
        bus.set_minv_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("abort_dout_valid", bus.dout_valid, 0);
            chk("abort_busy", bus.busy, 0);
            chk("abort_minv_en", bus.minv_en, 0);
            @(negedge clk);
        end

        run_job(256'd3, 256'd7, 4, 0, 7, 1, rnd256());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/minv_io_ctrl.md
MINV_IO_CTRL -- requirements
Module: minv_io_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32: host word width in bits.
REQ-002 SHALL have parameter NW, default 8: words per operand; DW*NW = 256.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port din, input, DW: host operand word.
REQ-006 SHALL have port din_valid, input, 1: din holds a valid word.
REQ-007 SHALL have port din_ready, output, 1: block accepts din this cycle.
REQ-008 SHALL have port dout, output, DW: result word to host.
REQ-009 SHALL have port dout_valid, output, 1: dout holds a valid word.
REQ-010 SHALL have port dout_ready, input, 1: host accepts dout this cycle.
REQ-011 SHALL have port minv_en, output, 1: one-cycle start pulse to the inversion engine.
REQ-012 SHALL have port opa, output, 256: operand a to invert, held stable from minv_en until completion.
REQ-013 SHALL have port modp, output, 256: modulus p, held stable from minv_en until completion.
REQ-014 SHALL have port set_minv_rdy, input, 1: engine done pulse.
REQ-015 SHALL have port minv_res, input, 256: engine result, valid while set_minv_rdy=1.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-017 SHALL have port err, output, 1: last job rejected; stays valid until the next job starts.

Function
REQ-018 SHALL implement states IDLE, LOAD_A, LOAD_P, CHECK, START, WAIT, UNLOAD.
REQ-019 SHALL use a 3-bit word counter cnt that is cleared on every state change and increments once per completed word transfer.
REQ-020 SHALL assert din_ready only in IDLE, LOAD_A and LOAD_P.
- A word transfers when din_valid & din_ready.
REQ-021 IDLE: a transfer SHALL store the word as opa word 0, clear err, set cnt=1 and go to LOAD_A.
REQ-022 LOAD_A: a transfer SHALL write opa word cnt, least significant word first.
- After the transfer with cnt=7, go to LOAD_P.
REQ-023 LOAD_P: a transfer SHALL write modp word cnt, least significant word first.
- After the transfer with cnt=7, go to CHECK.
REQ-024 CHECK (1 cycle): if opa==0, or modp[0]==0, or modp<=1, SHALL set err=1 and go to UNLOAD with the output buffer cleared to 0.
- Otherwise SHALL go to START.
REQ-025 START (1 cycle): SHALL drive minv_en=1 and go to WAIT.
- minv_en SHALL be 0 in all other states.
REQ-026 START or WAIT: when set_minv_rdy=1, SHALL capture minv_res into the 256-bit output buffer and go to UNLOAD next cycle.
REQ-027 WAIT has no timeout; set_minv_rdy SHALL be ignored in every other state.
REQ-028 UNLOAD: SHALL drive dout_valid=1 and dout = buffer word cnt, least significant word first.
- dout SHALL hold stable while dout_ready=0.
REQ-029 UNLOAD: a transfer (dout_valid & dout_ready) with cnt=7 SHALL return the block to IDLE.
REQ-030 opa and modp SHALL change only via LOAD_A/LOAD_P writes and IDLE word-0 writes.
REQ-031 din SHALL be ignored when din_ready=0.
REQ-032 din_valid=0 in a LOAD state SHALL stall with cnt unchanged; stalls of any length are legal.

Reset
REQ-033 rst=1 SHALL force state=IDLE, cnt=0, minv_en=0, dout_valid=0, err=0, opa=0, modp=0, output buffer=0.
- rst=1 SHALL hold busy=0 and din_ready=0 while rst=1.
REQ-034 rst asserted mid-job (any state) SHALL abort the job with no output words.
- A set_minv_rdy arriving after reset SHALL be ignored.

Verification
REQ-035 a=3, p=7 (16 words, each word 0 except word 0); model set_minv_rdy with minv_res=5 after 20 cycles -> one minv_en pulse, then dout words 0x00000005,0,0,0,0,0,0,0; err=0.
REQ-036 a=0, p=7 -> no minv_en; err=1; 8 dout words all 0; back to IDLE.
REQ-037 a=3, p=8 -> err=1; no minv_en.
REQ-038 din_valid toggling 1/0 every cycle during load, and dout_ready low for 3 cycles at word 4 -> identical result; dout word 4 held constant while stalled.
REQ-039 rst pulsed in WAIT, followed by set_minv_rdy -> state IDLE, dout_valid stays 0, busy=0.
REQ-040 set_minv_rdy asserted in the same cycle as minv_en -> result captured; UNLOAD entered next cycle.
